spram_delay_ctrl: RTL and testbench
===================================

Name: spram_delay_ctrl

Overview:
- Sequences the 16-bit x 1024 single-port audio sample RAM (output register enabled, 2-cycle read latency) as a circular delay line for the WM8731 path.
- Each accepted ADC sample is written at the write pointer. The sample written delay_len samples earlier is then read back and emitted toward the DAC.
- A secondary host port (debug/config) shares the same RAM. The stream has strict priority over the host port.

Parameters:
ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 16, sample width
RD_LATENCY, 2, RAM cycles from address to rd_data valid (output register on)

Ports:
clk  in  1  system clock, also drives the RAM
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ADC sample valid
in_data  in  DATA_WIDTH  ADC sample
in_ready  out  1  controller can accept a sample
delay_len  in  ADDR_WIDTH  delay in samples, sampled at accept
out_valid  out  1  one-cycle pulse, delayed sample valid
out_data  out  DATA_WIDTH  delayed sample
host_req  in  1  host access request, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_WIDTH  host read data, valid with host_ack
mem_addr  out  ADDR_WIDTH  to RAM addr
mem_wr_data  out  DATA_WIDTH  to RAM wr_data
mem_wr_en  out  1  to RAM wr_en
mem_rd_data  in  DATA_WIDTH  from RAM rd_data

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; wr_ptr=0; fill_cnt=0; in_ready=0; out_valid=0; out_data=0; host_ack=0; host_rdata=0; mem_wr_en=0; mem_addr=0; mem_wr_data=0.
- Reset mid-operation aborts the sequence: no out_valid and no host_ack are produced. RAM contents are not cleared.
- States: IDLE, S_WR, S_RD, S_WAIT, S_CAP, H_WR, H_RD, H_WAIT, H_CAP.
- in_ready = (state==IDLE); it is registered, so it goes high the cycle after reset deasserts.
- IDLE arbitration:
  - in_valid=1 → accept the stream sample (cycle T). Latch in_data and rd_addr = wr_ptr - delay_len (mod 2**ADDR_WIDTH).
  - Stream wins even if host_req=1.
  - Else if host_req=1 → H_WR when host_we=1, H_RD when host_we=0.
- Stream sequence:
  - T+1, S_WR: mem_addr=wr_ptr, mem_wr_data=sample, mem_wr_en=1.
  - End of T+1: wr_ptr+1 (1023→0 wrap); fill_cnt saturating increment to 2**ADDR_WIDTH.
  - T+2, S_RD: mem_addr=rd_addr, mem_wr_en=0.
  - T+3, S_WAIT: wait.
  - T+4, S_CAP: capture mem_rd_data.
  - T+5: out_valid=1; out_data = (delay_len > fill_cnt_at_accept) ? 0 : captured data. State returns to IDLE in the same cycle.
  - Sustained throughput is one sample per 5 cycles minimum.
- delay_len=0: reads the location just written, so out_data = in_data (passthrough, latency 5).
- Pre-fill masking: while fewer than delay_len samples have been stored, output is 0. This avoids emitting uninitialised RAM.
- Host write: H_WR drives mem_addr=host_addr, mem_wr_data=host_wdata, mem_wr_en=1 for one cycle. host_ack pulses the next cycle; state returns to IDLE.
- Host read:
  - H_RD presents host_addr.
  - H_WAIT, then H_CAP captures mem_rd_data.
  - Next cycle: host_ack=1 with host_rdata; state returns to IDLE.
- Host accesses do not move wr_ptr or fill_cnt.
- mem_wr_en is 1 only in S_WR and H_WR. Only one RAM access is ever issued per cycle.
- A request arriving outside IDLE waits; no input is ever dropped.

Decomposition:
- Shared package holds:
  - RAM geometry constants: ADDR_WIDTH=10, DATA_WIDTH=16, RD_LATENCY=2.
  - State encoding localparams.
- No sub-module is needed. The RAM IP is instantiated at the level above, and this block connects to its addr/wr_data/wr_en/rd_data. The RAM's clk_en is tied to 1 and its rst is driven by ~rst_n at the top.

Test Plan:
- Reset then delay_len=0, stream 0x1111 and 0x2222 with in_valid held → out_data 0x1111, 0x2222, each out_valid exactly 5 cycles after its accept; in_ready low 4 cycles between accepts.
- delay_len=3, stream 1..8 → outputs 0,0,0,1,2,3,4,5.
- delay_len=4, stream 1200 samples (value = index) → across the 1023→0 wrap, sample k outputs k-4; no glitch at wrap.
- Host write 0xBEEF @ 0x3FF, then host read @ 0x3FF with in_valid idle → host_ack 1 cycle after the write issue; read returns 0xBEEF, host_ack 4 cycles after leaving IDLE.
- host_req and in_valid asserted in the same cycle → stream served first; host_ack follows after the stream returns to IDLE; mem_wr_en never high in consecutive S_WR/H_WR cycles.
- rst_n low during S_WAIT → no out_valid, wr_ptr=0, fill_cnt=0; next sample with delay_len=1 outputs 0.

Source files
------------

// File: rtl/spram_delay_ctrl_pkg.sv
// Shared RAM geometry and controller state encoding for the audio delay line.
package spram_delay_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned FILL_WIDTH = ADDR_WIDTH + 1;
  localparam int unsigned WAIT_W     = 2;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_WR   = 4'd1,
    S_RD   = 4'd2,
    S_WAIT = 4'd3,
    S_CAP  = 4'd4,
    H_WR   = 4'd5,
    H_RD   = 4'd6,
    H_WAIT = 4'd7,
    H_CAP  = 4'd8
  } state_e;

endpackage

// File: rtl/spram_delay_ctrl.sv
// Circular delay-line sequencer for the single-port sample RAM, with a
// lower-priority host port sharing the same RAM.
module spram_delay_ctrl
  import spram_delay_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FILL_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    mask_q, mask_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    host_ack_q, host_ack_d;
  logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                    mem_wr_en_q, mem_wr_en_d;

  // Idle is only usable once in_ready has come up after reset; the cycle
  // carrying host_ack ignores host_req, which the host is still holding.
  logic idle_ok;
  assign idle_ok = in_ready_q;

  // Next-state, RAM command and output computation.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_cnt_d    = fill_cnt_q;
    rd_addr_d     = rd_addr_q;
    mask_d        = mask_q;
    wait_cnt_d    = wait_cnt_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    host_ack_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (idle_ok && in_valid) begin
          state_d       = S_WR;
          mem_addr_d    = wr_ptr_q;
          mem_wr_data_d = in_data;
          mem_wr_en_d   = 1'b1;
          rd_addr_d     = wr_ptr_q - delay_len;
          mask_d        = (FILL_WIDTH'(delay_len) > fill_cnt_q);
        end else if (idle_ok && host_req && !host_ack_q) begin
          mem_addr_d = host_addr;
          if (host_we) begin
            state_d       = H_WR;
            mem_wr_data_d = host_wdata;
            mem_wr_en_d   = 1'b1;
          end else begin
            state_d = H_RD;
          end
        end
      end
      S_WR: begin
        state_d    = S_RD;
        mem_addr_d = rd_addr_q;
        wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
        if (fill_cnt_q != FILL_WIDTH'(DEPTH)) begin
          fill_cnt_d = fill_cnt_q + FILL_WIDTH'(1);
        end
      end
      S_RD: begin
        state_d    = S_WAIT;
        wait_cnt_d = WAIT_W'(RD_LATENCY - 2);
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_CAP;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_CAP: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_data_d  = mask_q ? '0 : mem_rd_data;
      end
      H_WR: begin
        state_d    = IDLE;
        host_ack_d = 1'b1;
      end
      H_RD: begin
        state_d    = H_WAIT;
        wait_cnt_d = WAIT_W'(RD_LATENCY - 2);
      end
      H_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = H_CAP;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      H_CAP: begin
        state_d      = IDLE;
        host_ack_d   = 1'b1;
        host_rdata_d = mem_rd_data;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      fill_cnt_q    <= '0;
      rd_addr_q     <= '0;
      mask_q        <= 1'b0;
      wait_cnt_q    <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_cnt_q    <= fill_cnt_d;
      rd_addr_q     <= rd_addr_d;
      mask_q        <= mask_d;
      wait_cnt_q    <= wait_cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      host_ack_q    <= host_ack_d;
      host_rdata_q  <= host_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign host_ack    = host_ack_q;
  assign host_rdata  = host_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_en   = mem_wr_en_q;

endmodule

// File: tb/tb_spram_delay_ctrl.sv
// Bench for spram_delay_ctrl: behavioural RAM, reference delay-line model,
// directed steps followed by a randomized stream/host mix.
module tb_spram_delay_ctrl;
  import spram_delay_ctrl_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] delay_len;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  spram_delay_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .delay_len  (delay_len),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with output register: data appears two edges after addr.
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] ram_stage;
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    ram_stage   <= ram[mem_addr];
    mem_rd_data <= ram_stage;
  end

  // Count cycles where a RAM write directly follows another RAM write.
  logic prev_we = 1'b0;
  int   b2b_cnt = 0;
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1 && prev_we === 1'b1) b2b_cnt <= b2b_cnt + 1;
    prev_we <= mem_wr_en;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Reference: delay-line contents, samples stored since reset, write slot.
  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ref_wp;
  int                    ref_fill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [DATA_WIDTH-1:0] d, input logic [ADDR_WIDTH-1:0] dl,
                              output logic [DATA_WIDTH-1:0] e);
    logic [ADDR_WIDTH-1:0] src;
    ref_mem[ref_wp] = d;
    src = ref_wp - dl;
    e = (int'(dl) > ref_fill) ? '0 : ref_mem[src];
    ref_wp = ref_wp + ADDR_WIDTH'(1);
    if (ref_fill < int'(DEPTH)) ref_fill++;
  endtask

  // Entered and left on a negedge with the controller idle.
  task automatic stream(input logic [DATA_WIDTH-1:0] d, input logic [ADDR_WIDTH-1:0] dl,
                        output logic [DATA_WIDTH-1:0] got);
    logic [DATA_WIDTH-1:0] e;
    logic [ADDR_WIDTH-1:0] wp;
    int n;
    int lat;
    in_valid = 1'b1; in_data = d; delay_len = dl;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("s_ready", 32'(in_ready), 32'd1);
    wp = ref_wp;
    model_accept(d, dl, e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("s_wr_en", 32'(mem_wr_en), 32'd1);
    chk("s_wr_addr", 32'(mem_addr), 32'(wp));
    chk("s_wr_data", 32'(mem_wr_data), 32'(d));
    lat = -1;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = k; break; end
      if (k <= 4) chk("s_ready_low", 32'(in_ready), 32'd0);
    end
    chk("s_latency", 32'(lat), 32'd5);
    chk("s_data", 32'(out_data), 32'(e));
    got = out_data;
  endtask

  task automatic host(input logic we, input logic [ADDR_WIDTH-1:0] a,
                      input logic [DATA_WIDTH-1:0] wd);
    int lat;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (host_ack === 1'b1) begin lat = k; break; end
    end
    host_req = 1'b0;
    if (we) begin
      ref_mem[a] = wd;
      chk("h_wr_latency", 32'(lat), 32'd2);
    end else begin
      chk("h_rd_latency", 32'(lat), 32'd4);
      chk("h_rdata", 32'(host_rdata), 32'(ref_mem[a]));
    end
    @(negedge clk);
    chk("h_ack_pulse", 32'(host_ack), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ref_wp = '0;
    ref_fill = 0;
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] got;
    logic [DATA_WIDTH-1:0] e;
    logic [DATA_WIDTH-1:0] exp3 [8];
    int lat_o;
    int lat_h;
    int n;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; delay_len = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ref_wp = '0; ref_fill = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_up", 32'(in_ready), 32'd1);

    // Zero delay passthrough, back to back.
    stream(16'h1111, 10'd0, got);
    chk("pass_0", 32'(got), 32'h1111);
    stream(16'h2222, 10'd0, got);
    chk("pass_1", 32'(got), 32'h2222);

    // Delay of 3 with pre-fill masking.
    do_reset();
    exp3 = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    for (int i = 0; i < 8; i++) begin
      stream(16'(i + 1), 10'd3, got);
      chk("dly3", 32'(got), 32'(exp3[i]));
    end

    // Delay of 4 across the pointer wrap.
    do_reset();
    for (int k = 0; k < 1200; k++) begin
      stream(16'(k), 10'd4, got);
      chk("wrap", 32'(got), (k < 4) ? 32'd0 : 32'(k - 4));
    end

    // Host write then read at the top address.
    host(1'b1, 10'h3FF, 16'hBEEF);
    host(1'b0, 10'h3FF, 16'h0000);
    chk("host_beef", 32'(host_rdata), 32'hBEEF);

    // Stream and host requesting in the same cycle: stream first.
    in_valid = 1'b1; in_data = 16'h4242; delay_len = 10'd2;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h155; host_wdata = 16'hA5A5;
    chk("arb_ready", 32'(in_ready), 32'd1);
    model_accept(16'h4242, 10'd2, e);
    lat_o = -1; lat_h = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1 && lat_o < 0) begin lat_o = k; got = out_data; end
      if (host_ack === 1'b1 && lat_h < 0) begin lat_h = k; host_req = 1'b0; end
    end
    host_req = 1'b0;
    ref_mem[10'h155] = 16'hA5A5;
    chk("arb_out_lat", 32'(lat_o), 32'd5);
    chk("arb_out_data", 32'(got), 32'(e));
    chk("arb_ack_lat", 32'(lat_h), 32'd7);
    host(1'b0, 10'h155, 16'h0000);
    chk("arb_no_b2b_wr", 32'(b2b_cnt), 32'd0);

    // Reset while the stream is waiting on read data.
    in_valid = 1'b1; in_data = 16'h7777; delay_len = 10'd0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    model_accept(16'h7777, 10'd0, e);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    lat_o = -1; lat_h = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && lat_o < 0) lat_o = k;
      if (host_ack === 1'b1 && lat_h < 0) lat_h = k;
    end
    chk("mid_rst_no_out", 32'(lat_o), 32'hFFFF_FFFF);
    chk("mid_rst_no_ack", 32'(lat_h), 32'hFFFF_FFFF);
    ref_wp = '0; ref_fill = 0;
    stream(16'h8888, 10'd1, got);
    chk("mid_rst_masked", 32'(got), 32'd0);

    // Randomized mix of stream samples and host accesses.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0, 1: stream(16'($urandom), 10'($urandom_range(0, 12)), got);
        2:    host(1'b1, 10'($urandom_range(0, 1023)), 16'($urandom));
        default: host(1'b0, ($urandom_range(0, 1) == 1) ? ref_wp - 10'd1
                                                        : 10'($urandom_range(0, 1023)), 16'h0);
      endcase
    end
    chk("final_no_b2b_wr", 32'(b2b_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
